// File: rtl/irq_pending.sv
// Sticky request-capture stage feeding the priority encoder: pending bits, per-source mask, ack clear.
// Define IRQ_PENDING_EDGE_EN for rising-edge capture with overflow tracking; default is level capture.
module irq_pending #(
  parameter int WIDTH = 8,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           req_in,
  input  logic [WIDTH-1:0]           mask,
  input  logic                       ack,
  input  logic [IW-1:0]              ack_idx,
  input  logic                       clr,
  output logic [WIDTH-1:0]           pend_vec,
  output logic                       irq,
  output logic [$clog2(WIDTH+1)-1:0] pend_cnt,
  output logic [WIDTH-1:0]           ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] ackv;
  logic [WIDTH-1:0] pending_next;
  logic [CW-1:0]    cnt_next;

`ifdef IRQ_PENDING_EDGE_EN
  logic [WIDTH-1:0] req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else begin
      req_q <= req_in;
    end
  end

  assign evt = req_in & ~req_q;

  // A new event on a bit that is still pending and not being serviced this cycle is a lost request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= '0;
    end else if (clr) begin
      ovf <= '0;
    end else begin
      ovf <= ovf | (evt & pending & ~ackv);
    end
  end
`else
  assign evt = req_in;
  assign ovf = '0;
`endif

  // Indices at or above WIDTH match no source, so such an ack changes nothing.
  always_comb begin
    ackv = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ackv[i] = ack && (ack_idx == IW'(i));
    end
  end

  assign pending_next = clr ? '0 : ((pending & ~ackv) | evt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  assign pend_vec = pending & mask;
  assign irq      = |pend_vec;

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next = cnt_next + CW'(pend_vec[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt <= '0;
    end else begin
      pend_cnt <= cnt_next;
    end
  end

endmodule
